// File: rtl/cory_merge16.sv
`default_nettype none
// ============================================================================
// Module   : cory_merge16
// Purpose  : Round-robin merge of up to 16 valid/ready streams into one data
//            stream plus a 4-bit source-index stream, via one output slot.
// Option   : CORY_MERGE16_FIXED_PRI_EN selects fixed lowest-index priority.
// Revision : 1.0
// ============================================================================
module cory_merge16 #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [M-1:0]     i_a_v,
    input  logic [M*N-1:0]   i_a_d,
    output logic [M-1:0]     o_a_r,
    output logic             o_z_v,
    output logic [N-1:0]     o_z_d,
    input  logic             i_z_r,
    output logic             o_s_v,
    output logic [3:0]       o_s_d,
    input  logic             i_s_r
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic         pz;
    logic         ps;
    logic [N-1:0] slot_d;
    logic [3:0]   slot_idx;
    logic         free;
    logic         accept;
    logic         grant_found;
    logic [3:0]   grant_idx;
    logic [N-1:0] grant_d;
    logic [N-1:0] a_d_arr [M];

    generate
        for (genvar k = 0; k < M; k++) begin : g_unpack
            assign a_d_arr[k] = i_a_d[k*N +: N];
        end
    endgenerate

`ifndef CORY_MERGE16_FIXED_PRI_EN
    logic [3:0] ptr;
`endif

    assign free = (!pz || i_z_r) && (!ps || i_s_r);

    always_comb begin
        int ch;
        ch          = 0;
        grant_found = 1'b0;
        grant_idx   = 4'd0;
        grant_d     = '0;
        for (int i = 0; i < M; i++) begin
`ifdef CORY_MERGE16_FIXED_PRI_EN
            ch = i;
`else
            ch = int'(ptr) + i;
            if (ch >= M) ch = ch - M;
`endif
            if (!grant_found && i_a_v[IW'(ch)]) begin
                grant_found = 1'b1;
                grant_idx   = 4'(ch);
                grant_d     = a_d_arr[IW'(ch)];
            end
        end
    end

    // Gated by reset_n so no ready is offered while the slot is held in reset.
    assign accept = free && grant_found && reset_n;

    always_comb begin
        o_a_r = '0;
        for (int k = 0; k < M; k++) begin
            o_a_r[k] = accept && (grant_idx == 4'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pz       <= 1'b0;
            ps       <= 1'b0;
            slot_d   <= '0;
            slot_idx <= 4'd0;
        end else if (accept) begin
            pz       <= 1'b1;
            ps       <= 1'b1;
            slot_d   <= grant_d;
            slot_idx <= grant_idx;
        end else begin
            if (i_z_r) pz <= 1'b0;
            if (i_s_r) ps <= 1'b0;
        end
    end

`ifndef CORY_MERGE16_FIXED_PRI_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 4'd0;
        end else if (accept) begin
            ptr <= (grant_idx == 4'(M-1)) ? 4'd0 : grant_idx + 4'd1;
        end
    end
`endif

    assign o_z_v = pz;
    assign o_s_v = ps;
    assign o_z_d = slot_d;
    assign o_s_d = slot_idx;

endmodule
`default_nettype wire

// File: tb/tb_cory_merge16.sv
`default_nettype none
// Scoreboard bench for cory_merge16: directed scenarios plus random traffic,
// checked against a queue-based reference of the merge/arbitration rules.
module tb_cory_merge16;
    localparam int N = 8;
    localparam int M = 16;
`ifdef CORY_MERGE16_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [M-1:0]   i_a_v = '0;
    logic [M*N-1:0] i_a_d = '0;
    logic [M-1:0]   o_a_r;
    logic           o_z_v;
    logic [N-1:0]   o_z_d;
    logic           i_z_r = 1'b0;
    logic           o_s_v;
    logic [3:0]     o_s_d;
    logic           i_s_r = 1'b0;

    int nchk = 0;
    int nerr = 0;

    // reference model state
    bit           mz = 0, ms = 0;
    int           start = 0;
    logic [N-1:0] zq[$];
    logic [3:0]   sq[$];

    always #5 clk = ~clk;

    cory_merge16 #(.N(N), .M(M)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
        .o_z_v(o_z_v), .o_z_d(o_z_d), .i_z_r(i_z_r),
        .o_s_v(o_s_v), .o_s_d(o_s_d), .i_s_r(i_s_r)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: decides what the merge must do this cycle and records expected beats.
    always @(negedge clk) begin
        bit          mfree;
        int          g;
        logic [M-1:0] exp_r;
        if (!reset_n) begin
            mz = 0; ms = 0; start = 0;
            zq.delete(); sq.delete();
            check("rst_a_r", 32'(o_a_r), 0);
            check("rst_z_v", 32'(o_z_v), 0);
            check("rst_s_v", 32'(o_s_v), 0);
            check("rst_z_d", 32'(o_z_d), 0);
            check("rst_s_d", 32'(o_s_d), 0);
        end else begin
            check("z_v", 32'(o_z_v), 32'(mz));
            check("s_v", 32'(o_s_v), 32'(ms));
            mfree = (!mz || i_z_r) && (!ms || i_s_r);
            g = -1;
            for (int i = 0; i < M; i++) begin
                int c;
                c = (start + i) % M;
                if (g < 0 && i_a_v[c]) g = c;
            end
            exp_r = '0;
            if (mfree && g >= 0) exp_r[g] = 1'b1;
            check("a_r", 32'(o_a_r), 32'(exp_r));
            if (exp_r != '0) begin
                zq.push_back(i_a_d[g*N +: N]);
                sq.push_back(4'(g));
                mz = 1; ms = 1;
                start = FIXED ? 0 : (g + 1) % M;
            end else begin
                if (i_z_r) mz = 0;
                if (i_s_r) ms = 0;
            end
        end
    end

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_z_v) begin
                if (zq.size() == 0) check("z_unexpected", 32'(o_z_d), 32'hFFFF_FFFF);
                else begin
                    check("z_d", 32'(o_z_d), 32'(zq[0]));
                    if (i_z_r) void'(zq.pop_front());
                end
            end
            if (o_s_v) begin
                if (sq.size() == 0) check("s_unexpected", 32'(o_s_d), 32'hFFFF_FFFF);
                else begin
                    check("s_d", 32'(o_s_d), 32'(sq[0]));
                    if (i_s_r) void'(sq.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic [M-1:0] v, input logic zr, input logic sr);
        @(posedge clk); #1;
        i_a_v = v; i_z_r = zr; i_s_r = sr;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_a_v = '0;
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    function automatic int onehot_idx(input logic [M-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < M; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int exp_order[6];
        for (int k = 0; k < M; k++) i_a_d[k*N +: N] = 8'($urandom);
        i_a_v = '1;  // valid during reset must not raise any ready
        repeat (3) @(posedge clk);
        #1 i_a_v = '0; reset_n = 1'b1;

        // idle after reset
        repeat (10) cyc('0, 1'b1, 1'b1);

        // single beat from channel 3
        i_a_d[3*N +: N] = 8'h5A;
        cyc(16'h0008, 1'b1, 1'b1);
        @(negedge clk); check("single_a_r", 32'(o_a_r), 32'h0008);
        cyc('0, 1'b1, 1'b1);
        @(negedge clk);
        check("single_z_d", 32'(o_z_d), 32'h5A);
        check("single_s_d", 32'(o_s_d), 32'd3);
        // channels 3 and 4 valid: pointer now at 4 so channel 4 wins (fixed: 3)
        cyc(16'h0018, 1'b1, 1'b1);
        @(negedge clk); check("ptr_after_3", onehot_idx(o_a_r), FIXED ? 3 : 4);
        cyc('0, 1'b1, 1'b1);

        // fairness among 0, 5, 15
        do_reset();
        exp_order = FIXED ? '{0, 0, 0, 0, 0, 0} : '{0, 5, 15, 0, 5, 15};
        for (int i = 0; i < 6; i++) begin
            cyc(16'h8021, 1'b1, 1'b1);
            @(negedge clk); check("rr_order", onehot_idx(o_a_r), exp_order[i]);
        end
        cyc('0, 1'b1, 1'b1);
        cyc('0, 1'b1, 1'b1);

        // split drain: beat from 7, z drains first, channel 2 waits on s
        do_reset();
        cyc(16'h0080, 1'b1, 1'b1);
        cyc(16'h0004, 1'b1, 1'b0);
        @(negedge clk); check("split_a_r_blocked", 32'(o_a_r), 0);
        cyc(16'h0004, 1'b0, 1'b0);
        @(negedge clk);
        check("split_z_v", 32'(o_z_v), 0);
        check("split_s_v", 32'(o_s_v), 1);
        check("split_s_d", 32'(o_s_d), 7);
        check("split_a_r_wait", 32'(o_a_r), 0);
        cyc(16'h0004, 1'b0, 1'b1);
        @(negedge clk); check("split_a_r_go", 32'(o_a_r), 32'h0004);
        cyc('0, 1'b0, 1'b0);
        @(negedge clk); check("split_s_d_new", 32'(o_s_d), 2);
        cyc('0, 1'b1, 1'b1);
        cyc('0, 1'b1, 1'b1);

        // back-pressure: one accept of channel 1, slot held stable
        i_a_d[1*N +: N] = 8'hC3;
        for (int i = 0; i < 20; i++) cyc(16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_z_d", 32'(o_z_d), 32'hC3);
        check("bp_s_d", 32'(o_s_d), 1);
        check("bp_a_r", 32'(o_a_r), 0);

        // asynchronous reset with a beat pending
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async_z_v", 32'(o_z_v), 0);
        check("async_s_v", 32'(o_s_v), 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        i_a_v = 16'h0201; i_z_r = 1'b1; i_s_r = 1'b1;
        @(negedge clk); check("post_rst_grant", 32'(o_a_r), 32'h0001);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < M; k++) i_a_d[k*N +: N] = 8'($urandom);
            i_a_v = ($urandom_range(0, 3) == 0) ? '0 : M'($urandom & $urandom);
            i_z_r = ($urandom_range(0, 9) < 7);
            i_s_r = ($urandom_range(0, 9) < 7);
        end

        // drain and confirm nothing left outstanding
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 1'b1);
        @(negedge clk); #1;
        check("drain_zq", zq.size(), 0);
        check("drain_sq", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cory_merge16.md
Name: cory_merge16

Overview:
- Round-robin merge of up to 16 valid/ready input streams into one output data stream plus a 4-bit select stream.
- The select stream carries the index of the source channel for each output beat.
- Inverse of the 16-way select-driven demux. Pairing the two blocks routes a beat back to its originating channel (z_d to demux a_d, s_d to demux s_d).
- One registered output slot; z and s handshake independently.

Parameters:
- N, 8, data width per channel
- M, 16, number of active input channels (1..16); channels M..15 are absent

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_a_v  input  M  per-channel valid, bit k = channel k
- i_a_d  input  M*N  per-channel data, channel k at [k*N +: N]
- o_a_r  output  M  per-channel ready (one-hot or zero)
- o_z_v  output  1  merged data valid
- o_z_d  output  N  merged data
- i_z_r  input  1  merged data ready
- o_s_v  output  1  select valid
- o_s_d  output  4  source channel index of the current beat
- i_s_r  input  1  select ready

Behaviour:
- Reset (async, reset_n=0): o_z_v=0, o_s_v=0, o_z_d=0, o_s_d=0, rr pointer=0. o_a_r=0 during reset.
- State:
  - slot register {data N, index 4}
  - pending flags pz (drives o_z_v) and ps (drives o_s_v)
  - rr pointer ptr (4 bits, range 0..M-1)
- Slot free condition: free = (!pz || i_z_r) && (!ps || i_s_r). Both streams are drained, or are draining this cycle.
- Arbitration (combinational):
  - Search i_a_v starting at ptr, ascending, wrapping at M-1 to 0. The first valid channel g is granted.
  - o_a_r[g] = free && i_a_v[g]. All other o_a_r bits are 0.
  - o_a_r never asserts without i_a_v on the same bit.
- Accept (o_a_r[g]=1) at clock edge:
  - slot <= {i_a_d[g], g}
  - pz <= 1, ps <= 1
  - ptr <= (g==M-1) ? 0 : g+1
- No accept:
  - pz clears on o_z_v && i_z_r.
  - ps clears on o_s_v && i_s_r.
  - Each flag clears independently. ptr is held.
- Latency: accept at edge t gives o_z_v/o_s_v high from t. Back-to-back accepts are allowed when both consumers are ready every cycle, giving 1 beat/cycle.
- Stability: while o_z_v=1, o_z_d is stable. While o_s_v=1, o_s_d is stable. Slot contents change only on accept.
- Partial drain: if z handshakes and s does not, o_z_v drops and o_s_v stays high. No new accept until s completes, and vice versa.
- Simultaneous: the final handshake of the old beat and the accept of a new beat may occur in the same cycle. The flags stay 1 with new contents.
- No valid inputs while free: no accept. The slot empties as the handshakes complete.
- M<16: o_s_d upper bits beyond the needed index width are 0. Absent channels are never granted.
- M=1: ptr is always 0. o_s_d is always 0.
- Reset mid-beat: the pending beat is discarded, flags clear, ptr returns to 0.
- Input side has no combinational path from i_z_r/i_s_r to o_z_v/o_s_v. A path from i_z_r/i_s_r to o_a_r exists, through free.

Optional Feature:
- Macro: CORY_MERGE16_FIXED_PRI_EN.
- Defined: fixed priority, lowest-index valid channel always wins. ptr is not implemented, or is held at 0.
- Undefined: round-robin as specified above.
- All handshake, slot and reset rules are identical in both builds.

Test Plan:
- Reset release, no inputs valid (i_a_v=0): o_a_r=0, o_z_v=0, o_s_v=0 for 10 cycles.
- Single beat: ch3 valid, d=0x5A, both consumers ready. Response: o_a_r[3]=1 one cycle; next cycle o_z_d=0x5A, o_s_d=3; ptr=4.
- Round-robin fairness: ch0, ch5, ch15 held valid, consumers always ready. Grant order 0,5,15,0,5,15, one beat per cycle.
  - With CORY_MERGE16_FIXED_PRI_EN: grant order 0,0,0…
- Split drain: beat from ch7. Hold i_s_r=0, pulse i_z_r=1. o_z_v drops, o_s_v=1 with o_s_d=7, o_a_r=0 while ch2 waits. Raise i_s_r: same cycle o_a_r[2]=1, next o_s_d=2.
- Back-pressure: i_z_r=i_s_r=0 for 20 cycles with ch1 valid. Single accept only; o_z_d/o_s_d stable throughout; o_a_r=0 after the first accept.
- Async reset with o_z_v=1 pending: o_z_v/o_s_v go 0 immediately without a clock edge. After release, ch0 and ch9 valid: ch0 granted first.
